// File: rtl/aes_serial_pkg.sv
// Shared types, constants and GF(2^8)/round helpers for the serial AES wrapper.
// Block layout: byte i of the AES state is bits [8*i +: 8]; byte i sits in
// row i%4, column i/4 of the AES state matrix.
package aes_serial_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DRAIN} state_e;

  // Lane width must divide the block into a power-of-two number of beats
  function automatic bit lane_w_ok(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8) ||
           (w == 16) || (w == 32) || (w == 64) || (w == 128);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0). Only 8 inputs, so
  // synthesis folds this into a plain lookup per output bit.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] t;
    t = {x, x} << k;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r+4*((c+r)%4)) +: 8] = s[8*(r+4*c) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
      o[32*c+8 +: 8]  = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
      o[32*c+24 +: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[32*c+8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // One AES-128 key schedule step; word j is bits [32*j +: 32], low byte first
  function automatic logic [127:0] next_round_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, rot, t, n0, n1, n2, n3;
    w3  = k[127:96];
    rot = {w3[7:0], w3[31:8]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {24'h0, rc};
    n0  = k[31:0] ^ t;
    n1  = k[63:32] ^ n0;
    n2  = k[95:64] ^ n1;
    n3  = w3 ^ n2;
    return {n3, n2, n1, n0};
  endfunction

endpackage

// File: rtl/aes_decrypt.sv
// Combinational AES-128 inverse cipher (ten unrolled rounds).
module aes_decrypt
  import aes_serial_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  // Expand all round keys first, then apply them in reverse order
  always_comb begin
    logic [127:0] rk [0:10];
    logic [127:0] st;
    logic [7:0]   rc;
    rk[0] = key_i;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk[r] = next_round_key(rk[r-1], rc);
      rc = gf_mul(rc, 8'h02);
    end
    st = data_i ^ rk[10];
    for (int r = 9; r >= 0; r--) begin
      st = inv_sub_bytes(inv_shift_rows(st)) ^ rk[r];
      if (r != 0) st = inv_mix_columns(st);
    end
    data_o = st;
  end

endmodule

// File: rtl/aes_encrypt.sv
// Combinational AES-128 forward cipher (ten unrolled rounds).
module aes_encrypt
  import aes_serial_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  // Run the key schedule alongside the rounds
  always_comb begin
    logic [127:0] st;
    logic [127:0] rk;
    logic [7:0]   rc;
    st = data_i ^ key_i;
    rk = key_i;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk = next_round_key(rk, rc);
      rc = gf_mul(rc, 8'h02);
      st = shift_rows(sub_bytes(st));
      if (r != 10) st = mix_columns(st);
      st = st ^ rk;
    end
    data_o = st;
  end

endmodule

// File: rtl/aes_lane_deser.sv
// LANE_W -> 128-bit deserializer. block_o already includes the beat being
// accepted, so the owner can capture the full block on the last handshake.
module aes_lane_deser
  import aes_serial_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   beat_i,
  input  logic [LANE_W-1:0]      data_i,
  output logic [AES_BLOCK_W-1:0] block_o,
  output logic                   done_o
);

  localparam int BEATS = AES_BLOCK_W / LANE_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign done_o = beat_i && (cnt_q == CNT_W'(BEATS - 1));

  // Beat counter wraps to zero once the last slot is filled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (beat_i) cnt_q <= done_o ? '0 : cnt_q + 1'b1;
  end

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
    logic [LANE_W-1:0] slot_q;
    logic              hit;
    assign hit = beat_i && (cnt_q == CNT_W'(gi));
    // Each slot captures the beat addressed by the counter
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) slot_q <= '0;
      else if (hit) slot_q <= data_i;
    end
    assign block_o[gi*LANE_W +: LANE_W] = hit ? data_i : slot_q;
  end

endmodule

// File: rtl/aes_serial_core.sv
// Streaming AES wrapper: key/data in over a LANE_W lane, multicycle combinational
// cipher, result streamed back out low lane first.
module aes_serial_core
  import aes_serial_pkg::*;
#(
  parameter int LANE_W      = 8,
  parameter int COMP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_i,
  input  logic              key_load_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [LANE_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [LANE_W-1:0] out_data_o,
  output logic              busy_o
);

  localparam int BEATS  = AES_BLOCK_W / LANE_W;
  localparam int DCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CCNT_W = (COMP_CYCLES > 1) ? $clog2(COMP_CYCLES) : 1;

  if (!lane_w_ok(LANE_W) || COMP_CYCLES < 1) begin : g_bad_param
    $error("aes_serial_core: LANE_W must be a power of two in 1..128 and COMP_CYCLES >= 1");
  end

  state_e                 state_q;
  logic                   kl_q, mode_q;
  logic                   in_ready_q, out_valid_q, busy_q;
  logic [AES_BLOCK_W-1:0] key_q, block_q, result_q, result_d;
  logic [CCNT_W-1:0]      calc_cnt_q;
  logic [DCNT_W-1:0]      drain_cnt_q;
  logic [AES_BLOCK_W-1:0] deser_block, ct, pt;
  logic                   deser_done, in_fire, kl_cur;

  assign in_fire = in_valid_i && in_ready_q;
  // key_load is only meaningful on the first beat, which is taken in IDLE
  assign kl_cur  = (state_q == IDLE) ? key_load_i : kl_q;

  aes_lane_deser #(.LANE_W(LANE_W)) u_deser (
    .clk     (clk),
    .rst_n   (rst_n),
    .beat_i  (in_fire),
    .data_i  (in_data_i),
    .block_o (deser_block),
    .done_o  (deser_done)
  );

  // key_q/block_q stay frozen through CALC, so these are multicycle paths
  aes_encrypt u_enc (.key_i(key_q), .data_i(block_q), .data_o(ct));
  aes_decrypt u_dec (.key_i(key_q), .data_i(block_q), .data_o(pt));

  assign result_d = mode_q ? ct : pt;

  // Control FSM; handshake and status outputs are registered with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      kl_q        <= 1'b0;
      mode_q      <= 1'b0;
      key_q       <= '0;
      block_q     <= '0;
      result_q    <= '0;
      calc_cnt_q  <= '0;
      drain_cnt_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (in_fire) begin
            kl_q <= kl_cur;
            if (deser_done && kl_cur) begin
              key_q   <= deser_block;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (deser_done) begin
              block_q    <= deser_block;
              mode_q     <= mode_i;
              calc_cnt_q <= '0;
              state_q    <= CALC;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              state_q <= LOAD;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (calc_cnt_q == CCNT_W'(COMP_CYCLES - 1)) begin
            result_q    <= result_d;
            calc_cnt_q  <= '0;
            state_q     <= DRAIN;
            out_valid_q <= 1'b1;
          end else begin
            calc_cnt_q <= calc_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready_i) begin
            result_q <= result_q >> LANE_W;
            if (drain_cnt_q == DCNT_W'(BEATS - 1)) begin
              drain_cnt_q <= '0;
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              drain_cnt_q <= drain_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = result_q[LANE_W-1:0];
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_aes_serial_core.sv
// Scoreboard bench for aes_serial_core: one LANE_W=8 instance with the full
// directed suite plus three parameter-sweep instances running FIPS-197 C.1.
module tb_aes_serial_core;

  localparam int LW = 8;
  localparam int CC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // FIPS hex string order -> block layout (first byte in bits [7:0])
  function automatic logic [127:0] blk(input logic [127:0] fips);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fips[8*(15-i) +: 8];
    return r;
  endfunction

  localparam logic [127:0] F_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] F_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] F_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] F_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  // ---------------- main instance ----------------
  logic          rst_n, mode, key_load, in_valid, out_ready;
  logic [LW-1:0] in_data;
  logic          in_ready, out_valid, busy;
  logic [LW-1:0] out_data;

  aes_serial_core #(.LANE_W(LW), .COMP_CYCLES(CC)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (mode),
    .key_load_i  (key_load),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy)
  );

  logic [127:0] exp_q[$];
  int           last_in_cyc = 0;
  bit           blocked = 1'b0;
  int           mon_n = 0;

  task automatic send(input logic [127:0] d, input logic kl, input logic md, input int max_gap);
    int gap;
    int w;
    for (int b = 0; b < 16; b++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = d[8*b +: 8];
      key_load = (b == 0) ? kl : ~kl;
      mode     = (b == 15) ? md : ~md;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 400) begin @(negedge clk); w++; end
      if (!in_ready) begin
        chk("in_accept_timeout", {127'h0, in_ready}, 128'h1);
        $fatal(1, "input handshake never completed");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    last_in_cyc = cyc;
    if (!kl) blocked = 1'b1;
  endtask

  // Monitor: pops the scoreboard when a whole block has drained
  initial begin : main_monitor
    logic [127:0] acc;
    logic         prev_v, prev_r;
    logic [7:0]   prev_d;
    acc = '0; prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_n = 0; prev_v = 1'b0; prev_r = 1'b0; blocked = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          chk("stall_hold_valid", {127'h0, out_valid}, 128'h1);
          chk("stall_hold_data", {120'h0, out_data}, {120'h0, prev_d});
        end
        if (out_valid && !prev_v) chk("first_out_latency", 128'(cyc - last_in_cyc), 128'(CC));
        if (out_valid && out_ready) begin
          if (mon_n < 16) acc[8*mon_n +: 8] = out_data;
          mon_n++;
        end else if (mon_n != 0 && !out_valid) begin
          chk("drain_beats", 128'(mon_n), 128'd16);
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_block: got %h, expected no output", acc);
          end else begin
            chk("block_result", acc, exp_q.pop_front());
          end
          mon_n = 0;
          blocked = 1'b0;
        end
        if (blocked) begin
          chk("in_ready_calc_drain", {127'h0, in_ready}, 128'h0);
          chk("busy_calc_drain", {127'h0, busy}, 128'h1);
        end
        prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
      end
    end
  end

  // ---------------- parameter sweep instances ----------------
  logic sweep_rst_n;

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int SLW = (gi == 0) ? 1 : (gi == 1) ? 32 : 128;
    localparam int SCC = (gi == 1) ? 1 : 4;
    localparam int SB  = 128 / SLW;

    logic           s_in_valid, s_in_ready, s_out_valid, s_busy, s_mode, s_kl;
    logic [SLW-1:0] s_in_data, s_out_data;
    logic [127:0]   s_exp[$];
    bit             done = 1'b0;

    aes_serial_core #(.LANE_W(SLW), .COMP_CYCLES(SCC)) u_dut (
      .clk         (clk),
      .rst_n       (sweep_rst_n),
      .mode_i      (s_mode),
      .key_load_i  (s_kl),
      .in_valid_i  (s_in_valid),
      .in_ready_o  (s_in_ready),
      .in_data_i   (s_in_data),
      .out_valid_o (s_out_valid),
      .out_ready_i (1'b1),
      .out_data_o  (s_out_data),
      .busy_o      (s_busy)
    );

    task automatic s_send(input logic [127:0] d, input logic kl, input logic md);
      int w;
      for (int b = 0; b < SB; b++) begin
        s_in_valid = 1'b1;
        s_in_data  = d[b*SLW +: SLW];
        s_kl       = kl;
        s_mode     = md;
        w = 0;
        @(negedge clk);
        while (!s_in_ready && w < 1000) begin @(negedge clk); w++; end
        if (!s_in_ready) begin
          chk($sformatf("sweep_lw%0d_accept_timeout", SLW), {127'h0, s_in_ready}, 128'h1);
          $fatal(1, "sweep input handshake never completed");
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
      end
    endtask

    initial begin : sweep_stim
      int w;
      s_in_valid = 1'b0; s_in_data = '0; s_kl = 1'b0; s_mode = 1'b0;
      wait (sweep_rst_n);
      @(posedge clk); #1;
      s_send(blk(F_KEY), 1'b1, 1'b0);
      s_exp.push_back(blk(F_CT));
      s_send(blk(F_PT), 1'b0, 1'b1);
      s_exp.push_back(blk(F_PT));
      s_send(blk(F_CT), 1'b0, 1'b0);
      w = 0;
      while (s_exp.size() != 0 && w < 5000) begin @(posedge clk); w++; end
      if (s_exp.size() != 0) chk($sformatf("sweep_lw%0d_drain_timeout", SLW), 128'(s_exp.size()), 128'h0);
      done = 1'b1;
    end

    initial begin : sweep_monitor
      logic [127:0] sacc;
      int           sn;
      sacc = '0; sn = 0;
      forever begin
        @(negedge clk);
        if (sweep_rst_n) begin
          if (s_out_valid) begin
            for (int j = 0; j < SLW; j++) if (sn < SB) sacc[sn*SLW + j] = s_out_data[j];
            sn++;
          end else if (sn != 0) begin
            chk($sformatf("sweep_lw%0d_drain_beats", SLW), 128'(sn), 128'(SB));
            if (s_exp.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL sweep_lw%0d_unexpected_block: got %h, expected no output", SLW, sacc);
            end else begin
              chk($sformatf("sweep_lw%0d_cc%0d_result", SLW, SCC), sacc, s_exp.pop_front());
            end
            sn = 0;
          end
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin : main_stim
    int w;
    rst_n = 1'b0; sweep_rst_n = 1'b0;
    in_valid = 1'b0; mode = 1'b0; key_load = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; sweep_rst_n = 1'b1;
    #1;
    chk("reset_out_valid", {127'h0, out_valid}, 128'h0);
    chk("reset_busy", {127'h0, busy}, 128'h0);
    chk("reset_in_ready", {127'h0, in_ready}, 128'h1);
    chk("reset_out_data", {120'h0, out_data}, 128'h0);
    @(posedge clk); #1;

    // Zero key, zero block encrypt
    exp_q.push_back(blk(F_ZERO));
    send(128'h0, 1'b0, 1'b1, 0);
    $display("txn: zero-key encrypt issued");

    // Key load: IDLE again right after the last key beat, no output
    send(blk(F_KEY), 1'b1, 1'b0, 0);
    chk("key_done_in_ready", {127'h0, in_ready}, 128'h1);
    chk("key_done_busy", {127'h0, busy}, 128'h0);
    $display("txn: key 000102..0f loaded");

    // FIPS-197 C.1 encrypt, then decrypt with the same key
    exp_q.push_back(blk(F_CT));
    send(blk(F_PT), 1'b0, 1'b1, 0);
    $display("txn: C.1 encrypt issued");
    exp_q.push_back(blk(F_PT));
    send(blk(F_CT), 1'b0, 1'b0, 0);
    $display("txn: C.1 decrypt issued");

    // Input gaps plus 5-cycle output stall mid-drain
    exp_q.push_back(blk(F_CT));
    send(blk(F_PT), 1'b0, 1'b1, 3);
    w = 0;
    while (mon_n < 8 && w < 500) begin @(posedge clk); w++; end
    #1;
    if (mon_n < 8) chk("stall_wait_timeout", 128'(mon_n), 128'd8);
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    $display("txn: back-pressure encrypt issued");

    // Reset during drain beat 7
    exp_q.push_back(blk(F_CT));
    send(blk(F_PT), 1'b0, 1'b1, 0);
    w = 0;
    while (mon_n < 7 && w < 500) begin @(posedge clk); w++; end
    #1;
    if (mon_n < 7) chk("reset_wait_timeout", 128'(mon_n), 128'd7);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("midrst_busy", {127'h0, busy}, 128'h0);
    chk("midrst_out_data", {120'h0, out_data}, 128'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {127'h0, in_ready}, 128'h1);
    $display("txn: reset asserted mid-drain");

    // Key was cleared by reset: zero block gives the zero-key ciphertext
    exp_q.push_back(blk(F_ZERO));
    send(128'h0, 1'b0, 1'b1, 0);
    $display("txn: zero-block encrypt after reset issued");

    w = 0;
    while (!(exp_q.size() == 0 && g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && w < 20000) begin
      @(posedge clk); w++;
    end
    if (exp_q.size() != 0) chk("final_drain_timeout", 128'(exp_q.size()), 128'h0);
    if (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done))
      chk("sweep_done_timeout", {125'h0, g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}, 128'h7);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_serial_core.md
# aes_serial_core

Sequential, parametrised successor to the serial-bit AES top level. Accepts key and data blocks over a LANE_W-bit valid/ready stream and registers the 128-bit key. It runs the existing combinational aes_encrypt/aes_decrypt pair as a multicycle path, then streams the 128-bit result out over a second LANE_W-bit valid/ready stream. It is the FPGA-facing wrapper between pin/UART-level transport and the AES datapath.

## Interface
- LANE_W, 8, bits per beat; one of 1, 2, 4, 8, 16, 32, 64, 128; BEATS = 128/LANE_W
- COMP_CYCLES, 2, cycles the combinational core settles before capture; ≥1
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  1 = encrypt, 0 = decrypt; sampled with last data beat
- key_load  in  1  sampled with first beat of a transfer; 1 = transfer is a key, 0 = data block
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  LANE_W  input beat
- out_valid  out  1  output beat valid
- out_ready  in  1  output beat consumed when out_valid & out_ready
- out_data  out  LANE_W  output beat
- busy  out  1  state != IDLE

## Operation
- Bit order matches the codebase matrix layout. Beat k carries block bits [k*LANE_W +: LANE_W], so beat 0 holds bits [LANE_W-1:0]. With LANE_W=8, beat k is byte k. Output uses the same order.
- FSM states: IDLE, LOAD, CALC, DRAIN.
- IDLE: in_ready=1. An accepted beat stores beat 0 and latches key_load into kl_r. The beat counter is set to 1. Next state is LOAD, or the completion step below if BEATS=1.
- LOAD: in_ready=1. Each accepted beat fills the next slot and increments the counter. When in_valid is low, the FSM stalls with no timeout.
- Completion of the last beat:
  - If kl_r=1, the assembled value is written to the key register and the FSM returns to IDLE. No output is produced.
  - If kl_r=0, the value goes to the block register, mode is latched into mode_r, and the FSM goes to CALC.
- CALC: in_ready=0. Counts COMP_CYCLES cycles. On the edge ending the last CALC cycle, the result register loads ciphertext if mode_r=1, plaintext otherwise. Next state is DRAIN.
- DRAIN: out_valid=1, out_data = result[LANE_W-1:0]. Each accepted beat shifts the result right by LANE_W. After beat BEATS-1 is accepted, the FSM returns to IDLE.
- key_load and mode on non-sampling beats are ignored.
- The key persists across any number of data blocks until reloaded or reset.
- Single buffer: no new input is accepted during CALC or DRAIN.

## Timing
- Reset values:
  - state IDLE, key 0, block 0, result 0, counters 0, kl_r 0, mode_r 0.
  - out_valid=0, out_data=0, busy=0, in_ready=1 once rst_n is high.
- The key power-up value of 0 matches the fixed zero key of the previous generation.
- Last data beat accepted at cycle t:
  - CALC occupies cycles t+1 to t+COMP_CYCLES.
  - out_valid first high at t+COMP_CYCLES+1.
- Drain takes exactly BEATS cycles when out_ready is held high.
- IDLE is entered the cycle after the final output handshake. in_ready=1 in that cycle.
- Key transfer: IDLE is re-entered the cycle after the last key beat, with no dead cycle.
- out_ready low holds out_data and out_valid stable. Output never retracts.
- Reset asserted mid-transfer or mid-drain:
  - Immediate return to reset values.
  - The partial block is discarded.
  - The key is cleared.
- aes_encrypt and aes_decrypt paths are declared multicycle (COMP_CYCLES) in constraints. Inputs to them are stable for the whole CALC window.

## Structure
- Package aes_serial_pkg holds:
  - AES_BLOCK_W=128
  - state enum (IDLE/LOAD/CALC/DRAIN)
  - LANE_W legality check function
- Sub-module aes_lane_deser: LANE_W→128 deserializer with beat counter and done pulse. It is used for both key and data; the destination is chosen by kl_r.
- The top level instantiates one aes_encrypt and one aes_decrypt, both fed by the block and key registers, plus a result mux.

## Test plan
- Zero-key encrypt, LANE_W=8:
  - Stimulus: after reset, send a data block of all zeros with mode=1.
  - Required: 128-bit output 66e94bd4ef8a2c3b884cfa59ca342b2e (byte 0 = 0x66 first).
  - Required: first out_valid exactly COMP_CYCLES+1 cycles after the last input beat.
- FIPS-197 C.1 encrypt:
  - Stimulus: load key 000102…0f (key_load=1, byte 0x00 first), then plaintext 00112233445566778899aabbccddeeff with mode=1.
  - Required: output 69c4e0d86a7b0430d8cdb78070b4c55a.
- Decrypt with key persistence:
  - Stimulus: with the same key still loaded and no reload, send block 69c4e0d86a7b0430d8cdb78070b4c55a with mode=0.
  - Required: output 00112233445566778899aabbccddeeff.
- Back-pressure and stalls:
  - Stimulus: random in_valid gaps and out_ready low for 5 cycles mid-drain.
  - Required: identical data, out_data stable while stalled, in_ready=0 throughout CALC/DRAIN.
- Reset mid-operation:
  - Stimulus: assert rst_n low during DRAIN beat 7.
  - Required: out_valid=0 immediately and busy=0.
  - Required: a subsequent zero-block encrypt returns 66e94bd4…, confirming the key was cleared.
- Parameter sweep:
  - Stimulus: repeat the C.1 vector with LANE_W=1, 32, 128 and COMP_CYCLES=1, 4.
  - Required: correct results, with drain length exactly 128, 4, and 1 beats respectively.
